// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan driver.
//   scan_state_e : scan FSM state encoding (OFF / SHOW / BLANK)
//   SEG_0..SEG_F : glyph patterns, bit order [0:6] = a..g, 1 = segment lit
//   SEG_NONE     : all segments unlit
package seg7_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    localparam logic [0:6] SEG_0    = 7'b1111110;
    localparam logic [0:6] SEG_1    = 7'b0110000;
    localparam logic [0:6] SEG_2    = 7'b1101101;
    localparam logic [0:6] SEG_3    = 7'b1111001;
    localparam logic [0:6] SEG_4    = 7'b0110011;
    localparam logic [0:6] SEG_5    = 7'b1011011;
    localparam logic [0:6] SEG_6    = 7'b1011111;
    localparam logic [0:6] SEG_7    = 7'b1110000;
    localparam logic [0:6] SEG_8    = 7'b1111111;
    localparam logic [0:6] SEG_9    = 7'b1111011;
    localparam logic [0:6] SEG_A    = 7'b1110111;
    localparam logic [0:6] SEG_B    = 7'b0011111;
    localparam logic [0:6] SEG_C    = 7'b1001110;
    localparam logic [0:6] SEG_D    = 7'b0111101;
    localparam logic [0:6] SEG_E    = 7'b1001111;
    localparam logic [0:6] SEG_F    = 7'b1000111;
    localparam logic [0:6] SEG_NONE = 7'b0000000;

endpackage

// File: rtl/seg7_scan_driver_digit_decode.sv
// seg7_digit_decode: combinational nibble -> seven-segment glyph.
//   nibble   : 4-bit digit value
//   hex_mode : 1 = show 10..15 as A,b,C,d,E,F; 0 = show them unlit
//   pattern  : [0:6] = a..g, 1 = segment lit (active-high, not yet inverted)
module seg7_digit_decode (
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [0:6] pattern
);
    import seg7_pkg::*;

    always_comb begin
        pattern = SEG_NONE;
        case (nibble)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: if (hex_mode) pattern = SEG_A;
            4'hB: if (hex_mode) pattern = SEG_B;
            4'hC: if (hex_mode) pattern = SEG_C;
            4'hD: if (hex_mode) pattern = SEG_D;
            4'hE: if (hex_mode) pattern = SEG_E;
            4'hF: if (hex_mode) pattern = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS seven-segment digits.
//   clk, rst     : clock (rising edge) and synchronous active-high reset
//   enable       : display on while high
//   load         : one-cycle strobe capturing value/dp_in into the shadow register
//   value        : nibble i drives digit i (digit 0 least significant)
//   dp_in        : per-digit decimal point, active-high
//   segments     : [0:6] = a..g, active-low
//   dp_n         : decimal point, active-low
//   digit_sel_n  : one-cold digit enable, active-low
//   frame_start  : one-cycle pulse on the first lit cycle of digit 0
// Each digit is lit SCAN_DIV cycles followed by BLANK_CYC all-off cycles.
// Outputs are registered from the current state, so they trail it by a cycle.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter bit HEX_MODE   = 1'b0,
    parameter bit LZ_BLANK   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [0:6]              segments,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_start
);
    import seg7_pkg::*;

    localparam int DIV_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    scan_state_e             state;
    logic [IW-1:0]           idx;
    logic [CW-1:0]           cnt;
    logic [4*NUM_DIGITS-1:0] shadow_val, act_val;
    logic [NUM_DIGITS-1:0]   shadow_dp,  act_dp;

    logic [IW-1:0]           idx_nxt;
    logic                    show_done, blank_done, advance;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic [0:6]              cur_pat;
    logic [NUM_DIGITS-1:0]   sel_1h;
    logic [NUM_DIGITS-1:0]   lz;

    assign idx_nxt    = (idx == IDX_LAST) ? '0 : idx + IW'(1);
    assign show_done  = (state == SHOW)  && (cnt == SHOW_LAST);
    assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    // With no blanking interval the SHOW period hands straight to the next digit.
    assign advance    = blank_done || (show_done && (BLANK_CYC == 0));

    assign cur_nib = act_val[{idx, 2'b00} +: 4];
    assign cur_dp  = act_dp[idx];

    always_comb begin
        sel_1h = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            sel_1h[i] = (idx == IW'(i));
    end

    // lz[i]: digit i is a leading zero (it and every higher nibble are zero).
    // Digit 0 is always shown so a zero value still displays "0".
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
        if (i == 0) begin : g_d0
            assign lz[i] = 1'b0;
        end else begin : g_dn
            assign lz[i] = LZ_BLANK && (act_val[4*NUM_DIGITS-1:4*i] == '0);
        end
    end

    seg7_digit_decode u_decode (
        .nibble   (cur_nib),
        .hex_mode (HEX_MODE),
        .pattern  (cur_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= OFF;
            idx         <= '0;
            cnt         <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            act_val     <= '0;
            act_dp      <= '0;
            segments    <= '1;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
            frame_start <= 1'b0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end

            // Output stage: everything dark unless the current state is SHOW.
            segments    <= '1;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
            frame_start <= 1'b0;
            if (state == SHOW) begin
                digit_sel_n <= ~sel_1h;
                segments    <= lz[idx] ? '1 : ~cur_pat;
                dp_n        <= ~cur_dp;
                frame_start <= (idx == '0) && (cnt == '0);
            end

            if (!enable) begin
                state <= OFF;
                idx   <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    OFF: begin
                        state   <= SHOW;
                        idx     <= '0;
                        cnt     <= '0;
                        act_val <= shadow_val;
                        act_dp  <= shadow_dp;
                    end
                    SHOW: begin
                        if (show_done) begin
                            cnt   <= '0;
                            state <= (BLANK_CYC == 0) ? SHOW : BLANK;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    BLANK: begin
                        if (blank_done) begin
                            cnt   <= '0;
                            state <= SHOW;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= OFF;
                endcase

                // Shadow moves to active only when a new frame begins, so a
                // frame never mixes old and new digits. A load on this same
                // edge lands in the shadow and waits for the next frame.
                if (advance) begin
                    idx <= idx_nxt;
                    if (idx_nxt == '0) begin
                        act_val <= shadow_val;
                        act_dp  <= shadow_dp;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
    localparam int ND  = 4;
    localparam int SD  = 4;
    localparam int BC  = 2;
    localparam int NFR = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;

    logic [0:6]  seg_h, seg_p;
    logic        dpn_h, dpn_p;
    logic [3:0]  sel_h, sel_p;
    logic        fs_h, fs_p;

    always #5 clk = ~clk;

    // Hex glyphs with leading-zero blanking
    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
                       .HEX_MODE(1'b1), .LZ_BLANK(1'b1)) u_hex (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .segments(seg_h), .dp_n(dpn_h), .digit_sel_n(sel_h),
        .frame_start(fs_h));

    // Decimal-only glyphs, every digit shown
    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
                       .HEX_MODE(1'b0), .LZ_BLANK(1'b0)) u_plain (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
        .dp_in(dp_in), .segments(seg_p), .dp_n(dpn_p), .digit_sel_n(sel_p),
        .frame_start(fs_p));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference glyphs a..g (1 = lit), straight from the digit table.
    logic [6:0] glyph [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    // Active-low segments expected for digit i of value v.
    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int i,
                                           input bit hex, input bit lz);
        logic [15:0] hi;
        logic [3:0]  nib;
        hi  = v >> (4 * i);
        nib = hi[3:0];
        if (lz && i > 0 && hi == 16'h0) return 7'h7F;
        if (!hex && nib > 4'd9) return 7'h7F;
        return ~glyph[nib];
    endfunction

    typedef struct packed {
        logic [3:0] sel;
        logic [6:0] seg_h;
        logic [6:0] seg_p;
        logic       dpn;
    } exp_t;

    exp_t expq[$];
    bit   mon_on = 1'b0;

    task automatic push_frame(input logic [15:0] v, input logic [3:0] dp);
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            e.sel   = ~(4'b0001 << i);
            e.seg_h = exp_seg(v, i, 1'b1, 1'b1);
            e.seg_p = exp_seg(v, i, 1'b0, 1'b0);
            e.dpn   = ~dp[i];
            expq.push_back(e);
        end
    endtask

    // Monitor: every lit run is one digit; pop and compare at the end of it.
    initial begin : monitor
        logic [3:0] prev_sel, c_sel_p;
        logic [6:0] c_seg_h, c_seg_p;
        logic       c_dpn_h, c_dpn_p;
        int         run_len;
        bit         stable, seen;
        exp_t       e;
        prev_sel = '1; run_len = 0; stable = 1'b1; seen = 1'b0;
        c_sel_p = '1; c_seg_h = '1; c_seg_p = '1; c_dpn_h = 1'b1; c_dpn_p = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_on) begin
                prev_sel = '1; run_len = 0; seen = 1'b0;
                continue;
            end
            if (fs_h || fs_p)
                check("frame_start_align", {fs_p, prev_sel[0], sel_h[0]}, 3'b110);
            if (sel_h == prev_sel) begin
                run_len++;
                if (seg_h !== c_seg_h || seg_p !== c_seg_p || dpn_h !== c_dpn_h ||
                    dpn_p !== c_dpn_p || sel_p !== c_sel_p) stable = 1'b0;
            end else begin
                if (prev_sel != 4'hF) begin
                    if (expq.size() == 0) begin
                        n_chk++;
                        $display("FAIL scoreboard_underflow: lit run on sel %b, nothing expected", prev_sel);
                    end else begin
                        e = expq.pop_front();
                        check("digit_sel",       prev_sel, e.sel);
                        check("digit_sel_plain", c_sel_p,  e.sel);
                        check("seg_hex",         c_seg_h,  e.seg_h);
                        check("seg_plain",       c_seg_p,  e.seg_p);
                        check("dp_n",            c_dpn_h,  e.dpn);
                        check("dp_n_plain",      c_dpn_p,  e.dpn);
                        check("lit_len",         stable ? run_len : -1, SD);
                    end
                    seen = 1'b1;
                end else if (seen) begin
                    check("blank_len", run_len, BC);
                end
                prev_sel = sel_h; run_len = 1; stable = 1'b1;
                c_sel_p = sel_p; c_seg_h = seg_h; c_seg_p = seg_p;
                c_dpn_h = dpn_h; c_dpn_p = dpn_p;
            end
        end
    end

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (fs_h) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_chk++; $display("FAIL frame_start_timeout: no pulse within 60 cycles"); end
    endtask

    task automatic wait_lit(input int d, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (sel_h[d] == 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_chk++; $display("FAIL digit_timeout: digit %0d not lit within 60 cycles", d); end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        value = v; dp_in = dp; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_sel"},   sel_h, 4'hF);
        check({tag, "_seg"},   seg_h, 7'h7F);
        check({tag, "_dp"},    dpn_h, 1'b1);
        check({tag, "_fs"},    fs_h,  1'b0);
        check({tag, "_plain"}, {sel_p, seg_p, dpn_p, fs_p}, {4'hF, 7'h7F, 1'b1, 1'b0});
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] r;
        r = 16'($urandom);
        return r >> (4 * $urandom_range(0, 3));
    endfunction

    // Directed frames first: {value, mode}. Modes: 0 early load,
    // 1 load while digit 2 lit, 2 two loads (last wins), 3 load on the
    // frame transfer edge, 4 no load.
    logic [15:0] dir_val  [5] = '{16'h0007, 16'h0000, 16'h00AF, 16'h0000, 16'h1111};
    int          dir_mode [5] = '{0, 2, 3, 4, 1};

    initial begin : stim
        logic [15:0] sh_v, nv;
        logic [3:0]  sh_dp, ndp;
        int          mode;
        bit          ok;

        // Reset state, with a load strobe that must be ignored.
        value = 16'h9876; dp_in = 4'hF; load = 1'b1;
        repeat (3) @(negedge clk);
        check_dark("reset");
        rst = 1'b0; load = 1'b0;
        @(negedge clk);
        check_dark("idle_off");

        // Scoreboard phase.
        mon_on = 1'b1;
        sh_v = 16'h1234; sh_dp = 4'b0101;
        push_frame(sh_v, sh_dp);
        do_load(sh_v, sh_dp);
        enable = 1'b1;
        for (int f = 0; f < NFR; f++) begin
            wait_fs(ok);
            if (!ok) break;
            if (f == NFR - 1) break;
            if (f < 5) begin
                nv = dir_val[f]; mode = dir_mode[f];
            end else begin
                nv = rand_val(); mode = $urandom_range(0, 4);
            end
            ndp = 4'($urandom);
            case (mode)
                0: begin push_frame(nv, ndp); do_load(nv, ndp); sh_v = nv; sh_dp = ndp; end
                1: begin push_frame(nv, ndp); wait_lit(2, ok); do_load(nv, ndp); sh_v = nv; sh_dp = ndp; end
                2: begin
                    push_frame(nv, ndp);
                    do_load(~nv, ~ndp);
                    wait_lit(1, ok);
                    do_load(nv, ndp);
                    sh_v = nv; sh_dp = ndp;
                end
                3: begin
                    push_frame(sh_v, sh_dp);
                    repeat (22) @(negedge clk);
                    do_load(nv, ndp);
                    sh_v = nv; sh_dp = ndp;
                end
                default: push_frame(sh_v, sh_dp);
            endcase
        end
        begin : drain
            int n;
            for (n = 0; n < 80 && expq.size() != 0; n++) @(negedge clk);
            check("scoreboard_drain", expq.size(), 0);
        end
        mon_on = 1'b0;

        // Enable dropped while digit 2 is lit.
        wait_lit(2, ok);
        enable = 1'b0;
        @(negedge clk);
        check("disable_lag_sel", sel_h, 4'b1011);
        @(negedge clk);
        check_dark("disabled");
        repeat (3) @(negedge clk);
        check_dark("disabled_hold");
        enable = 1'b1;
        @(negedge clk);
        check("reenable_fs_early", {fs_h, sel_h}, {1'b0, 4'hF});
        @(negedge clk);
        check("reenable_fs", {fs_h, fs_p}, 2'b11);
        check("reenable_sel", sel_h, 4'b1110);
        check("reenable_seg_hex", seg_h, exp_seg(sh_v, 0, 1'b1, 1'b1));
        check("reenable_seg_plain", seg_p, exp_seg(sh_v, 0, 1'b0, 1'b0));

        // Reset asserted in a blanking interval, load strobed during reset.
        wait_lit(0, ok);
        for (int n = 0; n < 20 && sel_h != 4'hF; n++) @(negedge clk);
        rst = 1'b1; load = 1'b1; value = 16'h5A5A; dp_in = 4'hF;
        @(negedge clk);
        check_dark("rst_blank");
        @(negedge clk);
        check_dark("rst_hold");
        rst = 1'b0; load = 1'b0;
        wait_fs(ok);
        check("post_rst_sel", sel_h, 4'b1110);
        check("post_rst_seg_hex", seg_h, 7'b0000001);
        check("post_rst_seg_plain", seg_p, 7'b0000001);
        check("post_rst_dp", {dpn_h, dpn_p}, 2'b11);
        wait_lit(1, ok);
        check("post_rst_d1_hex", seg_h, 7'h7F);
        check("post_rst_d1_plain", seg_p, 7'b0000001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
